slave_bus_arbiter: RTL and testbench

- Shares the single slave bus among NUM_MASTERS requesters: the two SRAMs and the timer behind the address decoder.
- Slave bus signals are addr, idata, rw_ and the returned odata.
- Uses round-robin arbitration with a req/gnt handshake and a bounded tenure counter, so no master can starve the others.
- Sits between the masters (CPU cores, DMA) and the slave subsystem; it owns the only path into that subsystem's bus inputs.

---
 rtl/slave_bus_arbiter_pkg.sv | 24 ++
 rtl/slave_bus_arbiter_rr_picker.sv | 35 +++
 rtl/slave_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_slave_bus_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// slave_bus_arbiter_pkg : shared widths, state encoding and helpers
// Rev 1.0
// ============================================================================
package slave_bus_arbiter_pkg;

   localparam int BUS_ADDR_WIDTH  = 12;
   localparam int DATA_WIDTH      = 8;
   localparam int ARB_MAX_HOLD    = 16;
   localparam int ARB_NUM_MASTERS = 4;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_GAP   = 2'd2
   } arb_state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/slave_bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// slave_bus_arbiter_rr_picker : first requester after ptr_i, modulo count
// Rev 1.0
// ============================================================================
module slave_bus_arbiter_rr_picker
   import slave_bus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = ARB_NUM_MASTERS,
   parameter int IW          = idx_width(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [IW-1:0]          ptr_i,
   output logic [IW-1:0]          idx_o,
   output logic                   valid_o
);

   logic [IW-1:0] w_cand;

   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      w_cand  = '0;
      // Farthest offset first, so the nearest requester after ptr_i is written last and wins.
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         w_cand = IW'((int'(ptr_i) + k) % NUM_MASTERS);
         if (req_i[w_cand]) begin
            idx_o   = w_cand;
            valid_o = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/slave_bus_arbiter.sv
`default_nettype none
// ============================================================================
// slave_bus_arbiter : round-robin owner of the slave bus with bounded tenure
// Rev 1.0
// ============================================================================
module slave_bus_arbiter
   import slave_bus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = ARB_NUM_MASTERS,
   parameter int MAX_HOLD    = ARB_MAX_HOLD,
   parameter int AW          = BUS_ADDR_WIDTH,
   parameter int DW          = DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_MASTERS-1:0]    req,
   output logic [NUM_MASTERS-1:0]    gnt,
   input  logic [NUM_MASTERS*AW-1:0] m_addr,
   input  logic [NUM_MASTERS*DW-1:0] m_wdata,
   input  logic [NUM_MASTERS-1:0]    m_rw_,
   output logic [AW-1:0]             s_addr,
   output logic [DW-1:0]             s_wdata,
   output logic                      s_rw_,
   input  logic [DW-1:0]             s_rdata,
   output logic [DW-1:0]             m_rdata,
   output logic                      busy,
   output logic [2:0]                owner
);

   localparam int IW = idx_width(NUM_MASTERS);
   localparam int HW = idx_width(MAX_HOLD);
   localparam logic [IW-1:0]          C_PTR_RST   = IW'(NUM_MASTERS - 1);
   localparam logic [HW-1:0]          C_HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [NUM_MASTERS-1:0] C_ONE       = NUM_MASTERS'(1);

   arb_state_e             state_q;
   logic [NUM_MASTERS-1:0] gnt_q;
   logic                   busy_q;
   logic [IW-1:0]          owner_q;
   logic [IW-1:0]          ptr_q;
   logic [HW-1:0]          hold_q;
   logic [HW-1:0]          hold_d;

   logic [IW-1:0]          w_pick_idx;
   logic                   w_pick_valid;
   logic [AW-1:0]          w_addr  [NUM_MASTERS];
   logic [DW-1:0]          w_wdata [NUM_MASTERS];

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
      assign w_addr[i]  = m_addr[i*AW +: AW];
      assign w_wdata[i] = m_wdata[i*DW +: DW];
   end

   slave_bus_arbiter_rr_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .IW          (IW)
   ) u_picker (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .idx_o   (w_pick_idx),
      .valid_o (w_pick_valid)
   );

   assign hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         owner_q <= '0;
         ptr_q   <= C_PTR_RST;
         hold_q  <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (w_pick_valid) begin
                  gnt_q   <= C_ONE << w_pick_idx;
                  owner_q <= w_pick_idx;
                  ptr_q   <= w_pick_idx;
                  hold_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               hold_q <= hold_d;
               // The last permitted cycle of a tenure is hold_q == MAX_HOLD-1.
               if (!req[owner_q] || (hold_q == C_HOLD_LAST)) begin
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= ARB_GAP;
               end
            end
            ARB_GAP: begin
               state_q <= ARB_IDLE;
            end
            default: begin
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   // Idle bus parks in read mode so the slaves never see a stray write.
   always_comb begin
      s_addr  = '0;
      s_wdata = '0;
      s_rw_   = 1'b1;
      if (busy_q) begin
         s_addr  = w_addr[owner_q];
         s_wdata = w_wdata[owner_q];
         s_rw_   = m_rw_[owner_q];
      end
   end

   assign m_rdata = s_rdata;
   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign owner   = 3'(owner_q);

endmodule
`default_nettype wire

// File: tb/tb_slave_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_slave_bus_arbiter : directed bench with a cycle model and a slave memory
// Rev 1.0
// ============================================================================
module tb_slave_bus_arbiter;
   import slave_bus_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int MH = 16;
   localparam int AW = BUS_ADDR_WIDTH;
   localparam int DW = DATA_WIDTH;

   logic              clk     = 1'b0;
   logic              reset   = 1'b1;
   logic [N-1:0]      req     = '0;
   logic [N-1:0]      m_rw_   = '1;
   logic [N*AW-1:0]   m_addr  = '0;
   logic [N*DW-1:0]   m_wdata = '0;
   logic [N-1:0]      gnt;
   logic [AW-1:0]     s_addr;
   logic [DW-1:0]     s_wdata;
   logic              s_rw_;
   logic [DW-1:0]     s_rdata;
   logic [DW-1:0]     m_rdata;
   logic              busy;
   logic [2:0]        owner;

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   logic [DW-1:0] mem [1<<AW];

   slave_bus_arbiter #(
      .NUM_MASTERS (N),
      .MAX_HOLD    (MH),
      .AW          (AW),
      .DW          (DW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .gnt     (gnt),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rw_   (m_rw_),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_rw_   (s_rw_),
      .s_rdata (s_rdata),
      .m_rdata (m_rdata),
      .busy    (busy),
      .owner   (owner)
   );

   always #5 clk = ~clk;

   // Slave memory: asynchronous read, write on the edge where the bus carries a write.
   initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
   assign s_rdata = mem[s_addr];
   always @(posedge clk) if (busy === 1'b1 && s_rw_ === 1'b0) mem[s_addr] <= s_wdata;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: who owns the bus, how long they have had it, and dead cycles left before arbitration.
   int mdl_owner  = -1;
   int mdl_last   = N - 1;
   int mdl_tenure = 0;
   int mdl_dead   = 0;
   int mdl_disp   = 0;
   int mdl_c      = 0;

   always @(posedge clk) begin
      if (reset) begin
         mdl_owner = -1; mdl_last = N - 1; mdl_tenure = 0; mdl_dead = 0; mdl_disp = 0;
      end else if (mdl_owner >= 0) begin
         mdl_tenure++;
         if (!req[mdl_owner] || mdl_tenure >= MH) begin
            mdl_owner = -1;
            mdl_dead  = 1;
         end
      end else if (mdl_dead > 0) begin
         mdl_dead--;
      end else begin
         for (int k = 1; k <= N; k++) begin
            mdl_c = (mdl_last + k) % N;
            if (mdl_owner < 0 && req[mdl_c]) begin
               mdl_owner = mdl_c; mdl_last = mdl_c; mdl_disp = mdl_c; mdl_tenure = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         if (mdl_owner >= 0) begin
            check("gnt",     gnt,     N'(1) << mdl_owner);
            check("busy",    busy,    1);
            check("s_addr",  s_addr,  m_addr[mdl_owner*AW +: AW]);
            check("s_wdata", s_wdata, m_wdata[mdl_owner*DW +: DW]);
            check("s_rw_",   s_rw_,   m_rw_[mdl_owner]);
         end else begin
            check("gnt",     gnt,     0);
            check("busy",    busy,    0);
            check("s_addr",  s_addr,  0);
            check("s_wdata", s_wdata, 0);
            check("s_rw_",   s_rw_,   1);
         end
         check("owner",   owner,   mdl_disp);
         check("m_rdata", m_rdata, s_rdata);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_master(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rw);
      m_addr[i*AW +: AW]  = a;
      m_wdata[i*DW +: DW] = d;
      m_rw_[i]            = rw;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_gnt();
      for (int i = 0; i < 40 && gnt == '0; i++) tick();
      check("grant_seen", (gnt != '0), 1);
   endtask

   logic [N-1:0] run_val [$];
   int           run_len [$];

   task automatic collect_runs(input int ncyc);
      logic [N-1:0] prev;
      int run;
      prev = gnt;
      run  = 1;
      run_val.delete();
      run_len.delete();
      repeat (ncyc) begin
         tick();
         if (gnt == prev) run++;
         else begin
            run_val.push_back(prev);
            run_len.push_back(run);
            prev = gnt;
            run  = 1;
         end
      end
      run_val.push_back(prev);
      run_len.push_back(run);
   endtask

   task automatic check_runs(input string nm, input logic [N-1:0] ev [$], input int el [$]);
      check({nm, "_nruns"}, run_val.size(), el.size());
      for (int i = 0; i < el.size() && i < run_val.size(); i++) begin
         check($sformatf("%s_val%0d", nm, i), run_val[i], ev[i]);
         check($sformatf("%s_len%0d", nm, i), run_len[i], el[i]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] ev [$];
      int           el [$];

      // Reset state, then master 0 writes 0x5A to 0x010 and reads it back.
      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_gnt",   gnt,   0);
      check("rst_busy",  busy,  0);
      check("rst_owner", owner, 0);
      check("rst_rw",    s_rw_, 1);
      set_master(0, 12'h010, 8'h5A, 1'b0);
      req = 4'b0001;
      tick();
      check("t1_gnt_latency", gnt, 4'b0001);
      check("t1_s_addr",      s_addr, 12'h010);
      tick();
      tick();
      req = '0;
      repeat (3) tick();
      set_master(0, 12'h010, 8'h00, 1'b1);
      req = 4'b0001;
      wait_gnt();
      check("t1_readback", m_rdata, 8'h5A);
      req = '0;
      repeat (3) tick();

      // All four request continuously: 16-cycle tenures in order 0,1,2,3,0 with 2-cycle gaps.
      do_reset();
      req = 4'b1111;
      tick();
      check("t2_first", gnt, 4'b0001);
      collect_runs(75);
      ev = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
      el = '{16, 2, 16, 2, 16, 2, 16, 2, 4};
      check_runs("t2", ev, el);
      req = '0;
      repeat (3) tick();

      // A lone writer holding req for 40 cycles is forced off every 16.
      do_reset();
      set_master(0, 12'h000, 8'hC3, 1'b0);
      req = 4'b0001;
      tick();
      check("t3_first", gnt, 4'b0001);
      collect_runs(39);
      ev = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
      el = '{16, 2, 16, 2, 4};
      check_runs("t3", ev, el);
      req = '0;
      m_rw_ = '1;
      repeat (3) tick();

      // Master 2 owns; 1 and 3 arrive together; round-robin favours 3, then 1.
      do_reset();
      req = 4'b0100;
      tick();
      check("t4_m2", gnt, 4'b0100);
      repeat (3) tick();
      req = 4'b1110;
      repeat (3) tick();
      check("t4_hold", gnt, 4'b0100);
      req[2] = 1'b0;
      tick();
      wait_gnt();
      check("t4_m3", gnt, 4'b1000);
      check("t4_owner3", owner, 3);
      req[3] = 1'b0;
      tick();
      wait_gnt();
      check("t4_m1", gnt, 4'b0010);
      req[1] = 1'b0;
      repeat (3) tick();

      // Reset during a write tenure; later writes must not land.
      do_reset();
      set_master(1, 12'h120, 8'h33, 1'b0);
      req = 4'b0010;
      tick();
      check("t5_gnt", gnt, 4'b0010);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("t5_rst_gnt",  gnt,   0);
      check("t5_rst_rw",   s_rw_, 1);
      check("t5_rst_busy", busy,  0);
      set_master(1, 12'h120, 8'h77, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      req   = '0;
      set_master(1, 12'h120, 8'h77, 1'b1);
      tick();
      req = 4'b0010;
      wait_gnt();
      check("t5_readback", m_rdata, 8'h33);
      req = '0;
      repeat (3) tick();

      // One-cycle request pulse still earns a one-cycle grant, then GAP and IDLE.
      do_reset();
      req = 4'b0001;
      tick();
      req = '0;
      check("t6_on",    gnt,  4'b0001);
      check("t6_busy1", busy, 1);
      tick();
      check("t6_off1",  gnt,  0);
      check("t6_busy0", busy, 0);
      tick();
      check("t6_off2",  gnt,  0);
      tick();
      check("t6_off3",  gnt,  0);
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
